instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
// PC-generation and fetch stage directly upstream of the synchronous instruction ROM (1-cycle registered read).
// - Drives the ROM word address and realigns the ROM's registered output with the PC that produced it.
// - Absorbs decode-side stalls with a one-entry skid register and takes branch/jump redirects from execute.
// - Presents an IF/ID triple (inst, pc, valid) to decode and flags fetches outside the populated ROM.
// PARAMETERS
// RESET_PC   32'h0000_0000  PC loaded on reset
// ROM_WORDS  19             populated ROM words; valid byte addresses are 0 .. 4*ROM_WORDS-4
// NOP_INST   32'h0000_0013  instruction driven whenever if_valid_o=0 (addi x0,x0,0)
// PORTS
// clk            in   1   rising-edge clock
// rst            in   1   synchronous, active-high reset
// stall_i        in   1   decode cannot accept; hold current if_* outputs
// redirect_i     in   1   taken branch/jump resolved; fetch from redirect_pc_i
// redirect_pc_i  in   32  redirect target byte address
// rom_addr_o     out  32  address to ROM (sampled by ROM on posedge clk)
// rom_inst_i     in   32  ROM registered output for address sampled at previous edge
// if_inst_o      out  32  fetched instruction (NOP_INST when !if_valid_o)
// if_pc_o        out  32  byte address of if_inst_o
// if_valid_o     out  1   if_inst_o/if_pc_o are a real in-path instruction
// fetch_fault_o  out  1   sticky: out-of-range or misaligned fetch attempted
// BEHAVIOUR
// State: pc (next address), pend_pc/pend_valid (address ROM sampled last edge), hold_flag/hold_inst (skid), fault.
// in_range(a) = (a[1:0]==0) && (a[31:2] < ROM_WORDS).
// rom_addr_o = redirect_i ? redirect_pc_i : pc (comb). Redirect outranks stall and fault.
// Reset (rst=1 at edge): pc<=RESET_PC, pend_pc<=RESET_PC, pend_valid<=0, hold_flag<=0, hold_inst<=0, fault<=0.
//   => after reset: if_valid_o=0, if_pc_o=RESET_PC, if_inst_o=NOP_INST, fetch_fault_o=0, rom_addr_o=RESET_PC.
//   rst overrides stall_i/redirect_i; reset mid-stall or mid-redirect discards all state.
// Edge, redirect_i=1: pend_pc<=redirect_pc_i; pend_valid<=in_range(target); hold_flag<=0;
//   in range: pc<=target+4, fault<=0; else pc<=target, fault<=1.
// Edge, stall_i=1 (no redirect): pc, pend_* hold; if !hold_flag: hold_inst<=rom_inst_i, hold_flag<=1.
// Edge, normal (no stall/redirect): pend_pc<=pc; pend_valid<=in_range(pc)&&!fault; hold_flag<=0;
//   in range & !fault: pc<=pc+4 (32-bit wrap); else pc holds, fault<=1.
// Outputs (comb): raw = hold_flag ? hold_inst : rom_inst_i; if_pc_o=pend_pc;
//   if_valid_o = pend_valid && !redirect_i; if_inst_o = if_valid_o ? raw : NOP_INST.
// Latency: instruction at address A valid on if_* the cycle after A is on rom_addr_o; redirect costs 1 bubble.
// Stall release: skid contents shown in release cycle, next edge resumes at pc; no skipped/duplicated fetch.
// While fault=1: pc frozen, if_valid_o=0 until redirect to in-range target or rst.
// STRUCTURE
// Shared package: NOP_INST, ROM_WORDS default, RESET_PC default, function in_range().
// Sub-module: fetch_skid_buffer (hold_flag/hold_inst register + raw mux); remainder inline.
// Top-level integration wires rom_addr_o->ROM Address, ROM InstOut->rom_inst_i, same clk.
// TESTING (bench instantiates the 19-word ROM image: w0=00450693 w1=00100713 w2=00b76463 w3=00008067 w7=ffc62883 w18=fc1ff06f)
// 1 rst=1 two cycles, release -> 1st cycle valid=0,NOP; then pc=0 inst=00450693, pc=4 inst=00100713, pc=8 inst=00b76463.
// 2 stall_i=1 for 3 cycles while if_pc_o=0x8 -> outputs stay 0x8/00b76463 valid; after release next is 0xc/00008067.
// 3 redirect_i=1, target 0x1c while if_pc_o=0x10 -> that cycle valid=0; next cycle pc=0x1c inst=ffc62883 valid.
// 4 redirect and stall same cycle (target 0x4) -> redirect wins, skid cleared, next cycle pc=0x4 inst=00100713.
// 5 free-run to 0x48 -> pc=0x48 inst=fc1ff06f valid; then valid=0, fetch_fault_o=1, rom_addr_o frozen at 0x4c;
//   redirect to 0x0 -> fault=0, next cycle pc=0 inst=00450693. Redirect to 0x6 -> fault=1, valid=0.
// 6 rst=1 mid-stall with skid full -> next cycle valid=0, pc=RESET_PC, hold cleared; normal run resumes after release.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Holds reset/ROM defaults, the idle NOP encoding and the range check.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned ROM_WORDS_DEF = 19;

    // Word-aligned and inside the populated ROM image.
    function automatic logic in_range(
        input logic [31:0] a,
        input int unsigned words
    );
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < words);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch <-> decode/execute bundle: control into fetch, IF/ID out.
// master is the fetch side, slave the decode/execute side.
interface instruction_fetch_if;

    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_valid_o;
    logic        fetch_fault_o;

    modport master (
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        output if_inst_o,
        output if_pc_o,
        output if_valid_o,
        output fetch_fault_o
    );

    modport slave (
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        input  if_inst_o,
        input  if_pc_o,
        input  if_valid_o,
        input  fetch_fault_o
    );

endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry skid for the ROM output during decode stalls.
// Captures the word on the first stalled edge and replays it until release.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] raw_o
);

    logic        hold_flag_q;
    logic        hold_flag_d;
    logic [31:0] hold_inst_q;
    logic [31:0] hold_inst_d;

    // Capture once per stall; any redirect or non-stalled edge empties it.
    always_comb begin
        hold_flag_d = 1'b0;
        hold_inst_d = hold_inst_q;
        if (!redirect_i && stall_i) begin
            hold_flag_d = 1'b1;
            if (!hold_flag_q) begin
                hold_inst_d = rom_inst_i;
            end
        end
    end

    // Skid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_flag_q <= 1'b0;
            hold_inst_q <= 32'h0;
        end else begin
            hold_flag_q <= hold_flag_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // The ROM has moved on while stalled, so replay the captured word.
    always_comb begin
        raw_o = hold_flag_q ? hold_inst_q : rom_inst_i;
    end

endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch stage in front of a 1-cycle synchronous ROM.
// Tracks the address the ROM sampled so the returned word gets its PC.
import instruction_fetch_pkg::*;

module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned ROM_WORDS = ROM_WORDS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                rom_addr_o,
    input  logic [31:0]                rom_inst_i,
    instruction_fetch_if.master        dec_if
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pend_pc_q;
    logic [31:0] pend_pc_d;
    logic        pend_valid_q;
    logic        pend_valid_d;
    logic        fault_q;
    logic        fault_d;
    logic        tgt_ok;
    logic        pc_ok;
    logic [31:0] raw_inst;

    assign tgt_ok = in_range(dec_if.redirect_pc_i, ROM_WORDS);
    assign pc_ok  = in_range(pc_q, ROM_WORDS) && !fault_q;

    // Next PC / pending-fetch state; redirect beats stall beats fault.
    always_comb begin
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        fault_d      = fault_q;
        if (dec_if.redirect_i) begin
            pend_pc_d    = dec_if.redirect_pc_i;
            pend_valid_d = tgt_ok;
            if (tgt_ok) begin
                pc_d    = dec_if.redirect_pc_i + 32'd4;
                fault_d = 1'b0;
            end else begin
                pc_d    = dec_if.redirect_pc_i;
                fault_d = 1'b1;
            end
        end else if (!dec_if.stall_i) begin
            pend_pc_d    = pc_q;
            pend_valid_d = pc_ok;
            if (pc_ok) begin
                pc_d = pc_q + 32'd4;
            end else begin
                fault_d = 1'b1;
            end
        end
    end

    // PC, pending fetch and sticky fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            pend_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            fault_q      <= fault_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (dec_if.stall_i),
        .redirect_i (dec_if.redirect_i),
        .rom_inst_i (rom_inst_i),
        .raw_o      (raw_inst)
    );

    // ROM address and IF/ID outputs; a redirect squashes the word in flight.
    always_comb begin
        rom_addr_o           = dec_if.redirect_i ? dec_if.redirect_pc_i : pc_q;
        dec_if.if_pc_o       = pend_pc_q;
        dec_if.if_valid_o    = pend_valid_q && !dec_if.redirect_i;
        dec_if.if_inst_o     = dec_if.if_valid_o ? raw_inst : NOP_INST;
        dec_if.fetch_fault_o = fault_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector bench for instruction_fetch with a 19-word ROM model.
// Each vector drives one cycle's inputs and checks that cycle's outputs.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        logic [31:0] addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_q = 32'h0;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vt[$];

    instruction_fetch_if dif();

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr_o (rom_addr),
        .rom_inst_i (rom_q),
        .dec_if     (dif.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romw(input logic [31:0] w);
        case (w)
            32'd0:   return 32'h0045_0693;
            32'd1:   return 32'h0010_0713;
            32'd2:   return 32'h00b7_6463;
            32'd3:   return 32'h0000_8067;
            32'd7:   return 32'hffc6_2883;
            32'd18:  return 32'hfc1f_f06f;
            default: return (w < 32'd19) ? (32'h0100_0000 | w) : 32'hdead_beef;
        endcase
    endfunction

    // Synchronous ROM: registered read of the address seen at the edge.
    always @(posedge clk) rom_q <= romw({2'b00, rom_addr[31:2]});

    function automatic vec_t mk(
        input logic rs, input logic st, input logic rd, input logic [31:0] rp,
        input logic v, input logic [31:0] p, input logic f, input logic [31:0] a
    );
        vec_t r;
        r.rst = rs; r.stall = st; r.redir = rd; r.rpc = rp;
        r.valid = v; r.pc = p; r.fault = f; r.addr = a;
        r.inst = v ? romw({2'b00, p[31:2]}) : NOP;
        return r;
    endfunction

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst               = v.rst;
        dif.stall_i       = v.stall;
        dif.redirect_i    = v.redir;
        dif.redirect_pc_i = v.rpc;
        #1;
        n_vec++;
        if (dif.if_valid_o !== v.valid || dif.if_pc_o !== v.pc ||
            dif.if_inst_o !== v.inst || dif.fetch_fault_o !== v.fault ||
            rom_addr !== v.addr) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b pc=%h inst=%h fault=%0b addr=%h, want valid=%0b pc=%h inst=%h fault=%0b addr=%h",
                     name, dif.if_valid_o, dif.if_pc_o, dif.if_inst_o,
                     dif.fetch_fault_o, rom_addr, v.valid, v.pc, v.inst,
                     v.fault, v.addr);
        end
    endtask

    initial begin
        dif.stall_i       = 1'b0;
        dif.redirect_i    = 1'b0;
        dif.redirect_pc_i = 32'h0;

        // reset and first fetches
        vt.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0));
        vt.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0));
        vt.push_back(mk(0, 0, 0, 0,     1, 0,     0, 4));
        vt.push_back(mk(0, 0, 0, 0,     1, 4,     0, 8));
        // three-cycle stall at 0x8, then release
        vt.push_back(mk(0, 1, 0, 0,     1, 8,     0, 'hc));
        vt.push_back(mk(0, 1, 0, 0,     1, 8,     0, 'hc));
        vt.push_back(mk(0, 1, 0, 0,     1, 8,     0, 'hc));
        vt.push_back(mk(0, 0, 0, 0,     1, 8,     0, 'hc));
        vt.push_back(mk(0, 0, 0, 0,     1, 'hc,   0, 'h10));
        // redirect to 0x1c
        vt.push_back(mk(0, 0, 1, 'h1c,  0, 'h10,  0, 'h1c));
        vt.push_back(mk(0, 0, 0, 0,     1, 'h1c,  0, 'h20));
        // fill skid, then redirect+stall to 0x4
        vt.push_back(mk(0, 1, 0, 0,     1, 'h20,  0, 'h24));
        vt.push_back(mk(0, 1, 1, 'h4,   0, 'h20,  0, 'h4));
        vt.push_back(mk(0, 0, 0, 0,     1, 4,     0, 8));
        // free run to last ROM word
        for (int p = 8; p <= 'h48; p += 4)
            vt.push_back(mk(0, 0, 0, 0, 1, 32'(p), 0, 32'(p + 4)));
        // off the end: fault, frozen
        vt.push_back(mk(0, 0, 0, 0,     0, 'h4c,  1, 'h4c));
        vt.push_back(mk(0, 0, 0, 0,     0, 'h4c,  1, 'h4c));
        // recover via redirect to 0
        vt.push_back(mk(0, 0, 1, 0,     0, 'h4c,  1, 0));
        vt.push_back(mk(0, 0, 0, 0,     1, 0,     0, 4));
        // misaligned redirect
        vt.push_back(mk(0, 0, 1, 6,     0, 4,     0, 6));
        vt.push_back(mk(0, 0, 0, 0,     0, 6,     1, 6));
        vt.push_back(mk(0, 0, 1, 8,     0, 6,     1, 8));
        vt.push_back(mk(0, 0, 0, 0,     1, 8,     0, 'hc));
        // reset while skid is full
        vt.push_back(mk(0, 1, 0, 0,     1, 'hc,   0, 'h10));
        vt.push_back(mk(1, 1, 0, 0,     1, 'hc,   0, 'h10));
        vt.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0));
        vt.push_back(mk(0, 0, 0, 0,     1, 0,     0, 4));
        vt.push_back(mk(0, 0, 0, 0,     1, 4,     0, 8));

        repeat (2) @(posedge clk);
        foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

        // reset together with a redirect discards the redirect
        apply(mk(1, 0, 1, 'h1c, 0, 8, 0, 'h1c), "rst_redir");
        apply(mk(0, 0, 0, 0,    0, 0, 0, 0),    "rst_redir_after");
        apply(mk(0, 0, 0, 0,    1, 0, 0, 4),    "rst_redir_resume");
        // stall released straight into redirect
        apply(mk(0, 1, 0, 0,    1, 4, 0, 8),    "stall_pre");
        apply(mk(0, 0, 1, 'h48, 0, 4, 0, 'h48), "release_redir");
        apply(mk(0, 0, 0, 0,    1, 'h48, 0, 'h4c), "release_redir_tgt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
